// File: rtl/spike_rate_monitor.sv
// Spike firing-rate monitor: rising-edge event detect, windowed spike count and
// optional inter-spike interval capture (enabled by SPIKE_RATE_ISI_CAPTURE_EN).
module spike_rate_monitor #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_spike_in,
  input  logic             i_enable,
  input  logic [WIN_W-1:0] i_window_len,
  output logic [CNT_W-1:0] o_rate_out,
  output logic             o_rate_valid,
  output logic [CNT_W-1:0] o_isi_out,
  output logic             o_isi_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_spike_q;
  logic [WIN_W-1:0] r_last;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_spk_cnt;
  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic             w_event;
  logic             w_win_end;
  logic [CNT_W-1:0] w_spk_inc;

  assign w_event   = i_spike_in & ~r_spike_q & i_enable;
  assign w_spk_inc = (w_event && (r_spk_cnt != CNT_MAX)) ? r_spk_cnt + 1'b1 : r_spk_cnt;
  assign w_win_end = (r_state == S_RUN) && i_enable && (r_win_cnt == r_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  w_state_nxt = S_RUN;
      S_RUN:   if (w_win_end) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_LOAD;
      r_spike_q    <= 1'b0;
      r_last       <= '0;
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_spike_q    <= i_spike_in;
      r_rate_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          // Storing L-1 lets window_len==0 wrap to all-ones, i.e. a 2^WIN_W window.
          r_last    <= i_window_len - 1'b1;
          r_win_cnt <= '0;
          r_spk_cnt <= {{(CNT_W-1){1'b0}}, w_event};
        end
        S_RUN: begin
          if (i_enable) begin
            if (w_win_end) begin
              r_rate_out   <= w_spk_inc;
              r_rate_valid <= 1'b1;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              r_spk_cnt <= w_spk_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rate_out   = r_rate_out;
  assign o_rate_valid = r_rate_valid;

`ifdef SPIKE_RATE_ISI_CAPTURE_EN
  logic [CNT_W-1:0] r_isi_cnt;
  logic [CNT_W-1:0] r_isi_out;
  logic             r_isi_valid;
  logic             r_armed;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_isi_cnt   <= '0;
      r_isi_out   <= '0;
      r_isi_valid <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_isi_valid <= 1'b0;
      if (w_event) begin
        r_isi_cnt <= '0;
        r_armed   <= 1'b1;
        // The first event after reset only arms; later events report the gap.
        if (r_armed) begin
          r_isi_out   <= (r_isi_cnt == CNT_MAX) ? CNT_MAX : r_isi_cnt + 1'b1;
          r_isi_valid <= 1'b1;
        end
      end else if (i_enable && (r_isi_cnt != CNT_MAX)) begin
        r_isi_cnt <= r_isi_cnt + 1'b1;
      end
    end
  end

  assign o_isi_out   = r_isi_out;
  assign o_isi_valid = r_isi_valid;
`else
  assign o_isi_out   = '0;
  assign o_isi_valid = 1'b0;
`endif

endmodule

// File: doc/spike_rate_monitor.md
# spike_rate_monitor

Downstream consumer of the linear Hodgkin-Huxley neuron's `spike` output. Detects spike events, counts them over a programmable window of clock cycles to produce a firing-rate sample, and optionally measures the inter-spike interval (ISI). Results drive the spare `uo_out[6:0]` / `uio_out` pins for on-chip observation of neuron dynamics.

## Interface
- `WIN_W`, default 8: width of `window_len`; the maximum window is 2^WIN_W cycles.
- `CNT_W`, default 8: width of `rate_out` and `isi_out`. All counters saturate at 2^CNT_W-1.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spike_in`  in  1  neuron spike level; may stay high for several cycles.
- `enable`  in  1  when low: counters hold and events are ignored; edge register still tracks.
- `window_len`  in  WIN_W  window length in cycles; 0 means 2^WIN_W.
- `rate_out`  out  CNT_W  spike count of the last completed window.
- `rate_valid`  out  1  one-cycle strobe when `rate_out` updates.
- `isi_out`  out  CNT_W  cycles between the last two spike events (ISI_CAPTURE_EN only).
- `isi_valid`  out  1  one-cycle strobe when `isi_out` updates (ISI_CAPTURE_EN only).

## Operation
- Edge detect: `spike_q` <= `spike_in` every cycle, including while `enable` is low. Event = `spike_in & ~spike_q & enable`. Only a rising edge counts; a held-high spike is one event.
- Window FSM has two states, LOAD and RUN.
  - LOAD: entered on reset. Lasts one cycle. Latches L = (`window_len`==0 ? 2^WIN_W : `window_len`), clears `win_cnt` and `spk_cnt`, then goes to RUN. An event in the LOAD cycle is counted into the new window.
  - RUN: `win_cnt` increments each enabled cycle. Each event increments `spk_cnt`, saturating.
  - Final RUN cycle (`win_cnt` == L-1, enabled): `rate_out` <= sat(`spk_cnt` + event), `rate_valid` pulses, and the FSM returns to LOAD.
  - `window_len` is sampled only in LOAD. Changes mid-window take effect from the next window.
- ISI:
  - `isi_cnt` increments each enabled cycle, saturating at 2^CNT_W-1. It is cleared to 0 on each event.
  - `armed` is set by the first event after reset.
  - On an event with `armed`=1: `isi_out` <= sat(`isi_cnt`+1) and `isi_valid` pulses.
  - The first event after reset only arms the measurement and produces no output.
- Simultaneous window end and event: the event is counted in the ending window. `rate_valid` and `isi_valid` may pulse on the same cycle.
- `enable` low on the final window cycle delays the window end until `enable` returns high.

## Timing
- Reset values: `rate_out`=0, `rate_valid`=0, `isi_out`=0, `isi_valid`=0, `spike_q`=0, `armed`=0, all counters 0, state LOAD.
- Reset asserted mid-window discards the partial count. No strobe is emitted.
- Window period is L+1 cycles: L counting cycles plus 1 LOAD cycle. All cycles count events, so no spike is lost between windows.
- `rate_out` / `rate_valid` appear 1 cycle after the final RUN cycle.
- `isi_out` / `isi_valid` appear 1 cycle after the rising edge of `spike_in` is sampled.
- Minimum resolvable ISI is 2 (high, low, high on consecutive cycles).
- Outputs hold their value between strobes.

## Configuration
- `SPIKE_RATE_ISI_CAPTURE_EN` defined: ISI logic (`isi_cnt`, `armed`, `isi_out`, `isi_valid`) is built as described above.
- Not defined: ISI logic is omitted, and `isi_out` and `isi_valid` are tied to 0.
- Rate path is identical in both builds.

## Test plan
- Reset, then hold `window_len`=10 with `spike_in` low -> `rate_valid` pulses every 11 cycles with `rate_out`=0.
- `window_len`=20, 3 single-cycle spikes plus one spike held high 5 cycles -> `rate_out`=4.
- `window_len`=0, `spike_in` toggling every cycle (128 rising edges per 257-cycle period) -> rate_out=128 or 129, no lost events. A second run with `CNT_W`=6 must saturate `rate_out` at 63.
- ISI_CAPTURE_EN, spikes at cycles 5, 12, 400:
  - No `isi_valid` after the first spike.
  - `isi_out`=7 after the second spike.
  - `isi_out`=255 (saturated) after the third.
- Change `window_len` 10->4 mid-window -> the current window ends at 10 and the next at 4. Assert `reset` mid-window with 2 spikes counted -> no strobe, and all outputs are 0 on the next cycle.
- `enable` low for 5 cycles mid-window, with spikes during that time -> those spikes are not counted, and the window end is delayed by exactly 5 cycles.
